param_packet_router: RTL and testbench

//  Next-generation packet switch, generalised from the fixed 4-port router to NUM_PORTS outputs.

---
 rtl/param_packet_router_if.sv | 25 ++
 rtl/param_packet_router.sv | 144 ++++++++++++++
 tb/tb_param_packet_router.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/param_packet_router_if.sv
// param_packet_router_if: config bus, byte-serial packet input and per-port read bus
interface param_packet_router_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8
);
   logic                          mem_en;
   logic                          mem_rd_wr;
   logic [$clog2(NUM_PORTS):0]    mem_add;
   logic [DATA_W-1:0]             mem_data;
   logic [DATA_W-1:0]             mem_rdata;
   logic [DATA_W-1:0]             data;
   logic                          data_status;
   logic                          fifo_full;
   logic [NUM_PORTS-1:0]          ready;
   logic [NUM_PORTS-1:0]          read;
   logic [NUM_PORTS*DATA_W-1:0]   port_data;
   modport slave (
      input  mem_en, mem_rd_wr, mem_add, mem_data, data, data_status, read,
      output mem_rdata, fifo_full, ready, port_data
   );
   modport master (
      output mem_en, mem_rd_wr, mem_add, mem_data, data, data_status, read,
      input  mem_rdata, fifo_full, ready, port_data
   );
endinterface

// File: rtl/param_packet_router.sv
// param_packet_router: parses DA/LEN/payload/PAR packets and stores them into per-port
// FIFOs with speculative write pointers; bad packets are rewound and counted as drops.
module param_packet_router #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_PKT    = 258
) (
   input logic                 clk,
   input logic                 reset,
   param_packet_router_if.slave bus
);
   localparam int PI = $clog2(NUM_PORTS);
   localparam int AW = PI + 1;
   localparam int AD = $clog2(FIFO_DEPTH);
   localparam int PW = AD + 1;

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_PAR, S_WAIT, S_DRAIN} state_t;

   state_t              r_state, w_next;
   logic [DATA_W-1:0]   r_addr [NUM_PORTS];
   logic [DATA_W-1:0]   r_drop, r_rdata, r_xor, r_cnt;
   logic [PI-1:0]       r_dst, w_hit_idx, w_port, w_ma;
   logic                w_hit, w_wr, w_commit, w_rewind, w_drop, w_in_range, w_cfg_wr;
   logic [NUM_PORTS-1:0] w_full, w_near;

   assign w_ma       = bus.mem_add[PI-1:0];
   assign w_in_range = bus.mem_add < AW'(NUM_PORTS);
   assign w_cfg_wr   = bus.mem_en && bus.mem_rd_wr;
   assign w_port     = (r_state == S_IDLE) ? w_hit_idx : r_dst;
   assign bus.mem_rdata = r_rdata;
   assign bus.fifo_full = |w_near;

   // Reverse scan so the lowest matching index wins
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--)
         if (r_addr[k] == bus.data) begin
            w_hit     = 1'b1;
            w_hit_idx = PI'(k);
         end
   end

   always_comb begin
      w_next   = r_state;
      w_wr     = 1'b0;
      w_commit = 1'b0;
      w_rewind = 1'b0;
      w_drop   = 1'b0;
      case (r_state)
         S_IDLE: if (bus.data_status) begin
            if (!w_hit || w_full[w_port]) begin
               w_drop = 1'b1;
               w_next = S_DRAIN;
            end else begin
               w_wr   = 1'b1;
               w_next = S_LEN;
            end
         end
         S_LEN, S_PAY, S_PAR: begin
            if (!bus.data_status) begin
               w_rewind = 1'b1;
               w_drop   = 1'b1;
               w_next   = S_IDLE;
            end else if (w_full[w_port] || (r_state == S_LEN && bus.data == '0) ||
                         (r_state == S_PAR && bus.data != r_xor)) begin
               w_rewind = 1'b1;
               w_drop   = 1'b1;
               w_next   = S_DRAIN;
            end else begin
               w_wr     = 1'b1;
               w_commit = r_state == S_PAR;
               w_next   = r_state == S_LEN ? S_PAY :
                          r_state == S_PAR ? S_WAIT :
                          r_cnt == DATA_W'(1) ? S_PAR : S_PAY;
            end
         end
         default: if (!bus.data_status) w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_ff @(posedge clk)
      if (!reset) begin
         r_dst <= '0;
         r_xor <= '0;
         r_cnt <= '0;
      end else begin
         if (r_state == S_IDLE) r_dst <= w_hit_idx;
         if (w_wr) r_xor <= (r_state == S_IDLE) ? bus.data : r_xor ^ bus.data;
         if (r_state == S_LEN) r_cnt <= bus.data;
         else if (w_wr) r_cnt <= r_cnt - DATA_W'(1);
      end

   always_ff @(posedge clk)
      if (!reset) begin
         for (int k = 0; k < NUM_PORTS; k++) r_addr[k] <= DATA_W'(k);
         r_drop  <= '0;
         r_rdata <= '0;
      end else begin
         if (w_cfg_wr && w_in_range) r_addr[w_ma] <= bus.mem_data;
         if (w_cfg_wr && bus.mem_add == AW'(NUM_PORTS)) r_drop <= '0;
         else if (w_drop && r_drop != '1) r_drop <= r_drop + DATA_W'(1);
         if (bus.mem_en && !bus.mem_rd_wr)
            r_rdata <= w_in_range ? r_addr[w_ma] :
                       bus.mem_add == AW'(NUM_PORTS) ? r_drop : '0;
      end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [PW-1:0]     r_sp, r_wp, r_rp, w_used;
      logic [DATA_W-1:0] r_pd;
      logic              w_sel, w_pop;
      assign w_sel  = w_port == PI'(i);
      assign w_pop  = bus.read[i] && (r_wp != r_rp);
      assign w_used = r_wp - r_rp;
      assign w_full[i] = (r_sp - r_rp) == PW'(FIFO_DEPTH);
      assign w_near[i] = 32'(w_used) > 32'(FIFO_DEPTH - MAX_PKT);
      assign bus.ready[i] = r_wp != r_rp;
      assign bus.port_data[i*DATA_W +: DATA_W] = r_pd;
      always_ff @(posedge clk)
         if (w_wr && w_sel) r_mem[r_sp[AD-1:0]] <= bus.data;
      // Reader only ever sees entries below the committed pointer
      always_ff @(posedge clk)
         if (!reset) begin
            r_sp <= '0;
            r_wp <= '0;
            r_rp <= '0;
            r_pd <= '0;
         end else begin
            if (w_sel && w_rewind) r_sp <= r_wp;
            else if (w_sel && w_wr) r_sp <= r_sp + PW'(1);
            if (w_sel && w_commit) r_wp <= r_sp + PW'(1);
            if (w_pop) begin
               r_pd <= r_mem[r_rp[AD-1:0]];
               r_rp <= r_rp + PW'(1);
            end
         end
   end
endmodule

// File: tb/tb_param_packet_router.sv
// tb_param_packet_router: scoreboard bench; expected port bytes are queued per port when
// a packet that should commit is sent, and popped as the port is read.
module tb_param_packet_router;
   localparam int NP = 4, DW = 8, DEPTH = 512, MAXP = 258;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   param_packet_router_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();
   param_packet_router #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_PKT(MAXP))
      dut (.clk(clk), .reset(reset), .bus(bus));

   logic [7:0] q [NP][$];
   logic [7:0] m_addr [NP];
   logic [7:0] last [NP];
   logic [7:0] pl [$];
   int m_drop, n_vec, n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit exp_full();
      for (int k = 0; k < NP; k++) if (q[k].size() > DEPTH - MAXP) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drop_inc();
      if (m_drop < 255) m_drop++;
   endtask

   task automatic cfg_rd(input int a, input logic [7:0] e);
      @(negedge clk);
      bus.mem_en = 1'b1; bus.mem_rd_wr = 1'b0; bus.mem_add = 3'(a);
      @(negedge clk);
      bus.mem_en = 1'b0;
      chk($sformatf("cfg_rd%0d", a), 32'(bus.mem_rdata), 32'(e));
   endtask

   task automatic cfg_wr(input int a, input logic [7:0] v);
      @(negedge clk);
      bus.mem_en = 1'b1; bus.mem_rd_wr = 1'b1; bus.mem_add = 3'(a); bus.mem_data = v;
      @(negedge clk);
      bus.mem_en = 1'b0; bus.mem_rd_wr = 1'b0;
      if (a < NP) m_addr[a] = v;
      if (a == NP) m_drop = 0;
   endtask

   task automatic rd(input int p);
      @(negedge clk);
      chk($sformatf("ready%0d", p), 32'(bus.ready[p]), 32'(q[p].size() != 0));
      bus.read[p] = 1'b1;
      @(negedge clk);
      bus.read[p] = 1'b0;
      if (q[p].size() != 0) last[p] = q[p].pop_front();
      chk($sformatf("port_data%0d", p), 32'(bus.port_data[p*DW +: DW]), 32'(last[p]));
   endtask

   task automatic drain(input int p);
      while (q[p].size() != 0) rd(p);
   endtask

   // trunc >= 0 drops data_status after that many payload bytes
   task automatic send(input logic [7:0] da, input int len, input int trunc, input bit bad);
      logic [7:0] b [$];
      logic [7:0] par;
      int p;
      bit ok;
      b.push_back(da);
      b.push_back(8'(len));
      for (int i = 0; i < len; i++) b.push_back(i < pl.size() ? pl[i] : 8'($urandom));
      pl.delete();
      par = 8'h00;
      foreach (b[k]) par ^= b[k];
      b.push_back(bad ? par ^ 8'h07 : par);
      if (trunc >= 0) while (b.size() > 2 + trunc) void'(b.pop_back());
      p = -1;
      for (int k = NP - 1; k >= 0; k--) if (m_addr[k] == da) p = k;
      ok = 1'b0;
      if (p >= 0) ok = len != 0 && trunc < 0 && !bad && q[p].size() + b.size() <= DEPTH;
      if (!ok) drop_inc();
      for (int k = 0; k < b.size(); k++) begin
         @(negedge clk);
         if (ok && k == b.size() - 1)
            chk("pre_commit_ready", 32'(bus.ready[p]), 32'(q[p].size() != 0));
         bus.data = b[k];
         bus.data_status = 1'b1;
      end
      @(negedge clk);
      bus.data_status = 1'b0;
      bus.data = 8'h00;
      if (ok) foreach (b[k]) q[p].push_back(b[k]);
      if (p >= 0) chk("post_pkt_ready", 32'(bus.ready[p]), 32'(q[p].size() != 0));
   endtask

   initial begin
      bus.mem_en = 1'b0; bus.mem_rd_wr = 1'b0; bus.mem_add = '0; bus.mem_data = '0;
      bus.data = '0; bus.data_status = 1'b0; bus.read = '0;
      m_drop = 0; n_vec = 0; n_err = 0;
      for (int k = 0; k < NP; k++) begin m_addr[k] = 8'(k); last[k] = 8'h00; end
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'h0);
      chk("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
      chk("rst_port_data", bus.port_data, 32'h0);
      chk("rst_mem_rdata", 32'(bus.mem_rdata), 32'h0);
      reset = 1'b1;
      for (int a = 0; a < 8; a++) cfg_rd(a, a < NP ? m_addr[a] : 8'h00);

      // Good packet to port 2, then read it back plus one read on an empty port
      pl = '{8'h11, 8'h22, 8'h33};
      send(8'h02, 3, -1, 1'b0);
      repeat (7) rd(2);

      // Parity error, then a good packet to the same port
      pl = '{8'h11, 8'h22, 8'h33};
      send(8'h02, 3, -1, 1'b1);
      cfg_rd(NP, 8'(m_drop));
      send(8'h02, 4, -1, 1'b0);
      drain(2);

      // Unmatched DA, reprogram addr[1], overlapping match, zero length
      send(8'h77, 2, -1, 1'b0);
      cfg_rd(NP, 8'(m_drop));
      cfg_wr(1, 8'h77);
      cfg_wr(3, 8'h77);
      send(8'h77, 5, -1, 1'b0);
      drain(1);
      cfg_wr(3, 8'h03);
      send(8'h03, 0, -1, 1'b0);
      cfg_wr(6, 8'h55);
      for (int a = 0; a < 8; a++) cfg_rd(a, a < NP ? m_addr[a] : a == NP ? 8'(m_drop) : 8'h00);

      // Truncation after two of five payload bytes
      send(8'h00, 5, 2, 1'b0);
      cfg_rd(NP, 8'(m_drop));
      chk("trunc_ready0", 32'(bus.ready[0]), 32'h0);

      // Drop counter saturation and clear
      for (int n = 0; n < 260; n++) begin
         @(negedge clk); bus.data = 8'hEE; bus.data_status = 1'b1;
         @(negedge clk); bus.data_status = 1'b0; bus.data = 8'h00;
         drop_inc();
      end
      cfg_rd(NP, 8'(m_drop));
      cfg_wr(NP, 8'h00);
      cfg_rd(NP, 8'h00);

      // Fill port 0, overflow, then drain it while traffic goes to port 3
      send(8'h00, 255, -1, 1'b0);
      chk("fifo_full_1", 32'(bus.fifo_full), 32'(exp_full()));
      send(8'h00, 255, -1, 1'b0);
      cfg_rd(NP, 8'(m_drop));
      send(8'h00, 200, -1, 1'b0);
      chk("fifo_full_2", 32'(bus.fifo_full), 32'(exp_full()));
      fork
         drain(0);
         for (int n = 0; n < 4; n++) send(8'h03, int'($urandom_range(10, 50)), -1, 1'b0);
      join
      chk("fifo_full_3", 32'(bus.fifo_full), 32'(exp_full()));
      send(8'h00, 255, -1, 1'b0);
      send(8'h00, 100, -1, 1'b0);
      chk("fifo_full_4", 32'(bus.fifo_full), 32'(exp_full()));
      drain(0);
      drain(3);
      rd(0);
      cfg_rd(NP, 8'(m_drop));

      // Reset in the middle of a packet flushes committed data too
      send(8'h77, 6, -1, 1'b0);
      @(negedge clk); bus.data = 8'h02; bus.data_status = 1'b1;
      @(negedge clk); bus.data = 8'h09;
      @(negedge clk); bus.data = 8'hA5;
      @(negedge clk); reset = 1'b0; bus.data_status = 1'b0; bus.data = 8'h00;
      @(negedge clk); reset = 1'b1;
      for (int k = 0; k < NP; k++) begin q[k].delete(); m_addr[k] = 8'(k); last[k] = 8'h00; end
      m_drop = 0;
      chk("mid_rst_ready", 32'(bus.ready), 32'h0);
      chk("mid_rst_port_data", bus.port_data, 32'h0);
      cfg_rd(1, 8'h01);
      send(8'h01, 3, -1, 1'b0);
      drain(1);
      cfg_rd(NP, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
